nor_sweep_checker: RTL and testbench

- Controller that sequences an external N-input NOR gate under test through every input combination.
- Drives each input vector, waits a programmable settle time, then samples the gate output and compares it with the expected NOR.
- Counts mismatches and reports pass or fail.
- Sits beside the gate primitive as its self-check sequencer, replacing hand-written stimulus blocks in gate benches.

---
 rtl/nor_sweep_checker.sv | 111 +++++++++++
 tb/tb_nor_sweep_checker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/nor_sweep_checker.sv
// Self-check sequencer for an external N-input NOR gate: sweeps every input
// vector, samples the gate after a settle time and counts mismatches.
// Optional macro NOR_SWEEP_CHECKER_STOP_ON_ERR_EN: end the sweep at the first mismatch.
module nor_sweep_checker #(
  parameter int N_IN          = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N_IN-1:0]  dut_a,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [N_IN-1:0]  first_err_vec,
  output logic             first_err_valid
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0]  VEC_LAST    = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;
  logic             expected;
  logic             mismatch;
  logic             stop_now;
  logic [ERR_W-1:0] err_next;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  always_comb begin
    expected = ~|dut_a;
    mismatch = (dut_y != expected);
    err_next = mismatch ? sat_inc(err_count) : err_count;
`ifdef NOR_SWEEP_CHECKER_STOP_ON_ERR_EN
    stop_now = mismatch;
`else
    stop_now = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      settle_cnt      <= '0;
      dut_a           <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= SETTLE;
            settle_cnt      <= '0;
            dut_a           <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        SAMPLE: begin
          err_count <= err_next;
          if (mismatch && !first_err_valid) begin
            first_err_vec   <= dut_a;
            first_err_valid <= 1'b1;
          end
          // Terminal vector (or early stop) finishes; pass includes this cycle's result.
          if (stop_now || (dut_a == VEC_LAST)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            state      <= SETTLE;
            dut_a      <= dut_a + N_IN'(1);
            settle_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nor_sweep_checker.sv
// Directed bench for nor_sweep_checker: correct/stuck gate models, saturation,
// start-while-busy, mid-sweep reset, back-to-back sweeps and early stop.
module tb_nor_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   y_mode;  // 0: true NOR, 1: stuck at 0, 2: stuck at 1
  logic start0, start1, start2;
  int   checks = 0;
  int   errors = 0;

  logic [1:0] a0;  logic y0; logic busy0, done0, pass0; logic [7:0] err0; logic [1:0] fev0; logic fv0;
  logic [1:0] a1;  logic y1; logic busy1, done1, pass1; logic [0:0] err1; logic [1:0] fev1; logic fv1;
  logic [2:0] a2;  logic y2; logic busy2, done2, pass2; logic [7:0] err2; logic [2:0] fev2; logic fv2;

  assign y0 = (y_mode == 0) ? ~|a0 : (y_mode == 1) ? 1'b0 : 1'b1;
  assign y1 = (y_mode == 0) ? ~|a1 : (y_mode == 1) ? 1'b0 : 1'b1;
  assign y2 = (y_mode == 0) ? ~|a2 : (y_mode == 1) ? 1'b0 : 1'b1;

  nor_sweep_checker #(.N_IN(2), .SETTLE_CYCLES(1), .ERR_W(8)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .dut_a(a0), .dut_y(y0), .busy(busy0),
    .done(done0), .pass(pass0), .err_count(err0), .first_err_vec(fev0), .first_err_valid(fv0));

  nor_sweep_checker #(.N_IN(2), .SETTLE_CYCLES(1), .ERR_W(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_a(a1), .dut_y(y1), .busy(busy1),
    .done(done1), .pass(pass1), .err_count(err1), .first_err_vec(fev1), .first_err_valid(fv1));

  nor_sweep_checker #(.N_IN(3), .SETTLE_CYCLES(2), .ERR_W(8)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .dut_a(a2), .dut_y(y2), .busy(busy2),
    .done(done2), .pass(pass2), .err_count(err2), .first_err_vec(fev2), .first_err_valid(fv2));

  function automatic logic get_busy(input int w);
    case (w)
      0: return busy0;
      1: return busy1;
      default: return busy2;
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      0: start0 = v;
      1: start1 = v;
      default: start2 = v;
    endcase
  endtask

  // Pulse start for one cycle and count busy cycles (bounded).
  task automatic sweep(input int w, output int cyc);
    @(negedge clk); set_start(w, 1'b1);
    @(negedge clk); set_start(w, 1'b0);
    cyc = 0;
    while (get_busy(w) && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done0); end
    checks++; if (pass0 !== 1'b0) begin errors++; $display("FAIL reset_pass got=%b exp=0", pass0); end
    checks++; if (a0 !== 2'b00) begin errors++; $display("FAIL reset_dut_a got=%b exp=00", a0); end
    checks++; if (err0 !== 8'd0) begin errors++; $display("FAIL reset_err got=%0d exp=0", err0); end
    checks++; if ({fv0, fev0} !== 3'b000) begin errors++; $display("FAIL reset_first got=%b exp=000", {fv0, fev0}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_correct();
    int cyc;
    y_mode = 0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    cyc = 0;
    while (busy0 && cyc < 200) begin
      checks++;
      if (a0 !== 2'(cyc / 2)) begin errors++; $display("FAIL correct_step%0d dut_a got=%b exp=%b", cyc, a0, 2'(cyc / 2)); end
      cyc++;
      @(negedge clk);
    end
    checks++; if (cyc !== 8) begin errors++; $display("FAIL correct_busy_cycles got=%0d exp=8", cyc); end
    checks++; if ({done0, pass0} !== 2'b11) begin errors++; $display("FAIL correct_done_pass got=%b exp=11", {done0, pass0}); end
    checks++; if (err0 !== 8'd0) begin errors++; $display("FAIL correct_err got=%0d exp=0", err0); end
    checks++; if (fv0 !== 1'b0) begin errors++; $display("FAIL correct_fv got=%b exp=0", fv0); end
    checks++; if (a0 !== 2'b11) begin errors++; $display("FAIL correct_hold_a got=%b exp=11", a0); end
  endtask

  task automatic test_stuck0();
    int cyc;
    y_mode = 1;
    sweep(0, cyc);
    checks++; if ({done0, pass0} !== 2'b10) begin errors++; $display("FAIL stuck0_done_pass got=%b exp=10", {done0, pass0}); end
    checks++; if (err0 !== 8'd1) begin errors++; $display("FAIL stuck0_err got=%0d exp=1", err0); end
    checks++; if ({fv0, fev0} !== 3'b100) begin errors++; $display("FAIL stuck0_first got=%b exp=100", {fv0, fev0}); end
  endtask

  task automatic test_stuck1_saturate();
    int cyc;
    y_mode = 2;
    sweep(0, cyc);
    checks++; if (err0 !== 8'd3) begin errors++; $display("FAIL stuck1_err got=%0d exp=3", err0); end
    checks++; if ({fv0, fev0} !== 3'b101) begin errors++; $display("FAIL stuck1_first got=%b exp=101", {fv0, fev0}); end
    checks++; if ({done0, pass0} !== 2'b10) begin errors++; $display("FAIL stuck1_done_pass got=%b exp=10", {done0, pass0}); end
    sweep(1, cyc);
    checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL sat_err got=%0d exp=1", err1); end
    checks++; if ({done1, pass1} !== 2'b10) begin errors++; $display("FAIL sat_done_pass got=%b exp=10", {done1, pass1}); end
    checks++; if ({fv1, fev1} !== 3'b101) begin errors++; $display("FAIL sat_first got=%b exp=101", {fv1, fev1}); end
    checks++; if (cyc !== 8) begin errors++; $display("FAIL sat_busy_cycles got=%0d exp=8", cyc); end
  endtask

  task automatic test_start_while_busy();
    int cyc;
    y_mode = 0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    cyc = 0;
    while (busy0 && cyc < 200) begin
      start0 = (cyc == 3);
      cyc++;
      @(negedge clk);
    end
    start0 = 1'b0;
    checks++; if (cyc !== 8) begin errors++; $display("FAIL busy_start_cycles got=%0d exp=8", cyc); end
    checks++; if ({done0, pass0} !== 2'b11) begin errors++; $display("FAIL busy_start_pass got=%b exp=11", {done0, pass0}); end
  endtask

  task automatic test_reset_mid_sweep();
    int cyc;
    y_mode = 0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if ({busy0, a0} !== 3'b110) begin errors++; $display("FAIL mid_pre_reset got=%b exp=110", {busy0, a0}); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({busy0, done0, a0} !== 4'b0000) begin errors++; $display("FAIL mid_reset got=%b exp=0000", {busy0, done0, a0}); end
    rst_n = 1'b1;
    sweep(0, cyc);
    checks++; if (cyc !== 8) begin errors++; $display("FAIL post_reset_cycles got=%0d exp=8", cyc); end
    checks++; if ({done0, pass0, err0} !== {2'b11, 8'd0}) begin errors++; $display("FAIL post_reset_result got=%b/%0d exp=11/0", {done0, pass0}, err0); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    y_mode = 1;
    sweep(0, cyc);
    checks++; if ({done0, err0} !== {1'b1, 8'd1}) begin errors++; $display("FAIL b2b_first got=%b/%0d exp=1/1", done0, err0); end
    start0 = 1'b1;
    y_mode = 0;
    @(negedge clk);
    checks++; if ({busy0, done0, err0} !== {2'b10, 8'd0}) begin errors++; $display("FAIL b2b_restart got=%b/%0d exp=10/0", {busy0, done0}, err0); end
    start0 = 1'b0;
    cyc = 0;
    while (busy0 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    checks++; if (cyc !== 8) begin errors++; $display("FAIL b2b_cycles got=%0d exp=8", cyc); end
    checks++; if ({done0, pass0, err0} !== {2'b11, 8'd0}) begin errors++; $display("FAIL b2b_result got=%b/%0d exp=11/0", {done0, pass0}, err0); end
  endtask

  task automatic test_stop_on_err();
    int cyc;
    y_mode = 2;
    sweep(2, cyc);
`ifdef NOR_SWEEP_CHECKER_STOP_ON_ERR_EN
    checks++; if (cyc !== 6) begin errors++; $display("FAIL stop_cycles got=%0d exp=6", cyc); end
    checks++; if (err2 !== 8'd1) begin errors++; $display("FAIL stop_err got=%0d exp=1", err2); end
    checks++; if (a2 !== 3'b001) begin errors++; $display("FAIL stop_dut_a got=%b exp=001", a2); end
`else
    checks++; if (cyc !== 24) begin errors++; $display("FAIL n3_cycles got=%0d exp=24", cyc); end
    checks++; if (err2 !== 8'd7) begin errors++; $display("FAIL n3_err got=%0d exp=7", err2); end
    checks++; if (a2 !== 3'b111) begin errors++; $display("FAIL n3_dut_a got=%b exp=111", a2); end
`endif
    checks++; if ({done2, pass2} !== 2'b10) begin errors++; $display("FAIL n3_done_pass got=%b exp=10", {done2, pass2}); end
    checks++; if ({fv2, fev2} !== 4'b1001) begin errors++; $display("FAIL n3_first got=%b exp=1001", {fv2, fev2}); end
  endtask

  initial begin
    rst_n  = 1'b0;
    y_mode = 0;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    test_reset();
    test_correct();
    test_stuck0();
    test_stuck1_saturate();
    test_start_while_busy();
    test_reset_mid_sweep();
    test_back_to_back();
    test_stop_on_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
